// File: rtl/periph_mutex_pkg.sv
// rtl/periph_mutex_pkg.sv - shared types, word-format constants and op-word classifier for periph_mutex_n
package periph_mutex_pkg;

  typedef enum logic {IDLE, LOCKED} state_e;
  typedef enum logic [1:0] {W_IDLE, W_START, W_STOP, W_DATA} word_class_e;

  localparam logic [3:0]  CMD_PREFIX  = 4'hF;
  localparam logic [3:0]  START_PAD   = 4'h0;
  localparam logic [7:0]  STOP_SUFFIX = 8'hFF;
  localparam logic [15:0] IDLE_WORD   = 16'h0000;
  localparam logic [7:0]  IRQ_SEQ_DEF = 8'd78;

  // A tagged word with a zero priority nibble is not a start; it falls through to data.
  function automatic word_class_e classify(input logic [15:0] w, input logic [3:0] tag);
    if (w == IDLE_WORD) return W_IDLE;
    if (w[15:12] == CMD_PREFIX && w[11:8] == tag) begin
      if (w[7:0] == STOP_SUFFIX) return W_STOP;
      if (w[7:4] == START_PAD && w[3:0] != 4'h0) return W_START;
    end
    return W_DATA;
  endfunction

endpackage

// File: rtl/periph_mutex_n_prio_sel.sv
// rtl/periph_mutex_n_prio_sel.sv - combinational N-way max-priority selector, ties resolved from i_ptr upward
import periph_mutex_pkg::*;

module mutex_prio_sel #(
  parameter int NODES = 4,
  parameter int IDX_W = 2
) (
  input  logic [NODES-1:0]   i_req,
  input  logic [NODES*4-1:0] i_prio,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  logic       w_found;
  logic [3:0] w_best;
  int         w_j;

  // Scanning in rotation order with a strict compare keeps the first max seen.
  always_comb begin
    w_found = 1'b0;
    w_best  = 4'h0;
    w_j     = 0;
    o_idx   = '0;
    for (int i = 0; i < NODES; i++) begin
      w_j = (int'(i_ptr) + i) % NODES;
      if (i_req[w_j] && (!w_found || i_prio[w_j*4 +: 4] > w_best)) begin
        w_found = 1'b1;
        w_best  = i_prio[w_j*4 +: 4];
        o_idx   = IDX_W'(w_j);
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/periph_mutex_n.sv
// rtl/periph_mutex_n.sv - N-node peripheral mutex with IRQ lock and idle timeout; MUTEX_RR_EN enables round-robin ties
import periph_mutex_pkg::*;

module periph_mutex_n #(
  parameter int              NODES       = 4,
  parameter int              OP_W        = 16,
  parameter int              DATA_W      = 8,
  parameter logic [3:0]      TAG         = 4'b1011,
  parameter logic [DATA_W-1:0] IRQ_SEQ   = DATA_W'(IRQ_SEQ_DEF),
  parameter int              TIMEOUT_CYC = 1024,
  localparam int             IDX_W       = $clog2(NODES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NODES*OP_W-1:0] in_op,
  input  logic [DATA_W-1:0]     in_peripheral,
  input  logic                  in_irq_valid,
  input  logic [IDX_W-1:0]      in_irq_node,
  output logic [DATA_W-1:0]     out_peripheral,
  output logic [8+DATA_W-1:0]   out_node,
  output logic                  active,
  output logic [IDX_W-1:0]      owner,
  output logic [NODES-1:0]      out_irq,
  output logic                  timeout_evt
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  state_e              r_state,  w_state_nxt;
  logic [IDX_W-1:0]    r_owner,  w_owner_nxt;
  logic [DATA_W-1:0]   r_per,    w_per_nxt;
  logic [8+DATA_W-1:0] r_node,   w_node_nxt;
  logic [NODES-1:0]    r_irq,    w_irq_nxt;
  logic                r_to,     w_to_nxt;
  logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;

  logic [NODES-1:0]    w_req;
  logic [NODES*4-1:0]  w_prio;
  logic [IDX_W-1:0]    w_ptr;
  logic                w_sel_valid;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_grant;
  logic [OP_W-1:0]     w_own_word;
  word_class_e         w_own_class;
  logic [7:0]          w_oh8;
  logic                w_irq_ok;

  for (genvar k = 0; k < NODES; k++) begin : g_node
    assign w_req[k]          = (classify(in_op[k*OP_W +: OP_W], TAG) == W_START);
    assign w_prio[k*4 +: 4]  = in_op[k*OP_W +: 4];
  end

  mutex_prio_sel #(.NODES(NODES), .IDX_W(IDX_W)) u_sel (
    .i_req   (w_req),
    .i_prio  (w_prio),
    .i_ptr   (w_ptr),
    .o_valid (w_sel_valid),
    .o_idx   (w_sel_idx)
  );

  assign w_own_word  = in_op[r_owner*OP_W +: OP_W];
  assign w_own_class = classify(w_own_word, TAG);
  assign w_oh8       = 8'd1 << r_owner;
  assign w_irq_ok    = ({1'b0, in_irq_node} < (IDX_W+1)'(NODES));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_per   <= '0;
      r_node  <= '0;
      r_irq   <= '0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_per   <= w_per_nxt;
      r_node  <= w_node_nxt;
      r_irq   <= w_irq_nxt;
      r_to    <= w_to_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_per_nxt   = r_per;
    w_node_nxt  = r_node;
    w_irq_nxt   = '0;
    w_to_nxt    = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        w_per_nxt   = '0;
        w_node_nxt  = '0;
        w_owner_nxt = '0;
        w_cnt_nxt   = '0;
        if (in_irq_valid && w_irq_ok) begin
          w_grant     = 1'b1;
          w_owner_nxt = in_irq_node;
        end else if (w_sel_valid) begin
          w_grant     = 1'b1;
          w_owner_nxt = w_sel_idx;
        end
        if (w_grant) w_state_nxt = LOCKED;
      end
      LOCKED: begin
        case (w_own_class)
          W_DATA: begin
            w_per_nxt          = w_own_word[DATA_W-1:0];
            w_node_nxt         = {w_oh8, in_peripheral};
            w_irq_nxt[r_owner] = (in_peripheral == IRQ_SEQ);
            w_cnt_nxt          = '0;
          end
          W_IDLE: begin
            if (TIMEOUT_CYC != 0 && r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
              w_state_nxt = IDLE;
              w_owner_nxt = '0;
              w_per_nxt   = '0;
              w_node_nxt  = '0;
              w_cnt_nxt   = '0;
              w_to_nxt    = 1'b1;
            end else if (r_cnt != '1) begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          W_START: begin
            w_per_nxt  = '0;
            w_node_nxt = '0;
            w_cnt_nxt  = '0;
          end
          default: begin
            w_state_nxt = IDLE;
            w_owner_nxt = '0;
            w_per_nxt   = '0;
            w_node_nxt  = '0;
            w_cnt_nxt   = '0;
          end
        endcase
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef MUTEX_RR_EN
  logic [IDX_W-1:0] r_rr_ptr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_owner_nxt == IDX_W'(NODES - 1)) ? '0 : w_owner_nxt + 1'b1;
    end
  end

  assign w_ptr = r_rr_ptr;
`else
  assign w_ptr = '0;
`endif

  assign out_peripheral = r_per;
  assign out_node       = r_node;
  assign active         = (r_state == LOCKED);
  assign owner          = r_owner;
  assign out_irq        = r_irq;
  assign timeout_evt    = r_to;

endmodule

// File: tb/tb_periph_mutex_n.sv
// tb/tb_periph_mutex_n.sv - directed and randomized checks of periph_mutex_n against a behavioural model
module tb_periph_mutex_n;

  localparam int N  = 4;
  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] in_op;
  logic [7:0]  in_peripheral;
  logic        in_irq_valid;
  logic [1:0]  in_irq_node;
  logic [7:0]  out_peripheral;
  logic [15:0] out_node;
  logic        active;
  logic [1:0]  owner;
  logic [3:0]  out_irq;
  logic        timeout_evt;

  periph_mutex_n #(.NODES(N), .TIMEOUT_CYC(TO)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .in_op          (in_op),
    .in_peripheral  (in_peripheral),
    .in_irq_valid   (in_irq_valid),
    .in_irq_node    (in_irq_node),
    .out_peripheral (out_peripheral),
    .out_node       (out_node),
    .active         (active),
    .owner          (owner),
    .out_irq        (out_irq),
    .timeout_evt    (timeout_evt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          m_locked = 0;
  int          m_owner  = 0;
  int          m_cnt    = 0;
  int          m_rr     = 0;
  logic [7:0]  m_per    = '0;
  logic [15:0] m_node   = '0;
  logic [3:0]  m_irq    = '0;
  bit          m_to     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] opw(input int k);
    return in_op[k*16 +: 16];
  endfunction

  function automatic bit is_start(input logic [15:0] w);
    return (w[15:8] == 8'hFB) && (w[7:4] == 4'h0) && (w[3:0] != 4'h0);
  endfunction

  task automatic m_release();
    m_locked = 0; m_owner = 0; m_per = '0; m_node = '0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [15:0] w;
    int g, bp, idx;
    m_to  = 0;
    m_irq = '0;
    if (RST) begin
      m_release();
      m_rr = 0;
    end else if (!m_locked) begin
      m_release();
      g  = -1;
      bp = 0;
      if (in_irq_valid && int'(in_irq_node) < N) begin
        g = int'(in_irq_node);
      end else begin
        for (int off = 0; off < N; off++) begin
          idx = (m_rr + off) % N;
          w   = opw(idx);
          if (is_start(w) && int'(w[3:0]) > bp) begin
            g  = idx;
            bp = int'(w[3:0]);
          end
        end
      end
      if (g >= 0) begin
        m_locked = 1;
        m_owner  = g;
`ifdef MUTEX_RR_EN
        m_rr = (g + 1) % N;
`endif
      end
    end else begin
      w = opw(m_owner);
      if (w == 16'h0000) begin
        if (m_cnt == TO - 1) begin
          m_release();
          m_to = 1;
        end else begin
          m_cnt++;
        end
      end else if (w == 16'hFBFF) begin
        m_release();
      end else if (is_start(w)) begin
        m_per = '0; m_node = '0; m_cnt = 0;
      end else begin
        m_per          = w[7:0];
        m_node         = {8'(1 << m_owner), in_peripheral};
        m_irq[m_owner] = (in_peripheral == 8'd78);
        m_cnt          = 0;
      end
    end
  endtask

  task automatic step(input logic [15:0] w0, w1, w2, w3, input logic iv, input logic [1:0] inode,
                      input logic [7:0] per, input logic rst);
    in_op         = {w3, w2, w1, w0};
    in_irq_valid  = iv;
    in_irq_node   = inode;
    in_peripheral = per;
    RST           = rst;
    model_edge();
    @(posedge CLK);
    #1;
    chk("active", 32'(active), 32'(m_locked));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("out_peripheral", 32'(out_peripheral), 32'(m_per));
    chk("out_node", 32'(out_node), 32'(m_node));
    chk("out_irq", 32'(out_irq), 32'(m_irq));
    chk("timeout_evt", 32'(timeout_evt), 32'(m_to));
    cyc++;
  endtask

  function automatic logic [15:0] rand_word();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 16'h0000;
    if (r == 5) return {8'hFB, 4'h0, 4'($urandom_range(1, 15))};
    if (r == 6) return 16'hFBFF;
    return 16'($urandom);
  endfunction

  initial begin
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("reset_active", 32'(active), 32'd0);
    chk("reset_node", 32'(out_node), 32'd0);

    step(16'h0, 16'h0, 16'hFB03, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("tp_lock_active", 32'(active), 32'd1);
    chk("tp_lock_owner", 32'(owner), 32'd2);
    step(16'h0, 16'h0, 16'h0041, 16'h0, 1'b0, 2'd0, 8'h99, 1'b0);
    chk("tp_data_per", 32'(out_peripheral), 32'h41);
    chk("tp_data_oh", 32'(out_node[15:8]), 32'h04);
    step(16'h0, 16'h0, 16'hFBFF, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);

    step(16'hFB05, 16'h0, 16'h0, 16'hFB09, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("tp_prio_owner", 32'(owner), 32'd3);
    step(16'h0, 16'h0, 16'h0, 16'hFBFF, 1'b0, 2'd0, 8'h00, 1'b0);
    step(16'hFB07, 16'hFB07, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("tp_tie_owner", 32'(owner), 32'd0);
    step(16'hFBFF, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);

    step(16'h0, 16'hFB01, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    step(16'h0055, 16'h0033, 16'h0, 16'h0, 1'b0, 2'd0, 8'h12, 1'b0);
    chk("tp_owner_only", 32'(out_peripheral), 32'h33);
    step(16'h0055, 16'hFBFF, 16'h0, 16'h0, 1'b0, 2'd0, 8'h12, 1'b0);
    chk("tp_stop_active", 32'(active), 32'd0);
    chk("tp_stop_node", 32'(out_node), 32'd0);

    step(16'hFB02, 16'h0, 16'h0, 16'h0, 1'b1, 2'd1, 8'h00, 1'b0);
    chk("tp_irq_owner", 32'(owner), 32'd1);
    step(16'h0, 16'h0010, 16'h0, 16'h0, 1'b0, 2'd0, 8'd78, 1'b0);
    chk("tp_irq_flag", 32'(out_irq), 32'b0010);
    step(16'h0, 16'hFBFF, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);

    step(16'h0, 16'h0, 16'hFB04, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    step(16'h0, 16'h0, 16'h0077, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("tp_no_early_to", 32'(active), 32'd1);
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("tp_to_evt", 32'(timeout_evt), 32'd1);
    chk("tp_to_active", 32'(active), 32'd0);
    step(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("tp_to_pulse", 32'(timeout_evt), 32'd0);

    step(16'h0, 16'h0, 16'h0, 16'hFB06, 1'b0, 2'd0, 8'h00, 1'b0);
    step(16'h0, 16'h0, 16'h0, 16'h00AA, 1'b0, 2'd0, 8'd78, 1'b0);
    step(16'h0, 16'h0, 16'h0, 16'h00AA, 1'b0, 2'd0, 8'd78, 1'b1);
    chk("tp_rst_active", 32'(active), 32'd0);
    chk("tp_rst_irq", 32'(out_irq), 32'd0);
    step(16'hFB01, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("tp_post_rst", 32'(active), 32'd1);

    for (int i = 0; i < 800; i++) begin
      step(rand_word(), rand_word(), rand_word(), rand_word(),
           1'($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 8'd78 : 8'($urandom),
           1'($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
